// File: rtl/draw_rect_if.sv
// VGA timing/pixel bundle shared by the draw stages.
// Field widths match the background drawer: 11-bit counters, RGB444.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_rect.sv
// Paints a solid WIDTH x HEIGHT rectangle over the incoming VGA stream with a fixed 2-cycle latency.
// Optional blinking is enabled by defining DRAW_RECT_BLINK_EN.
module draw_rect #(
    parameter int unsigned WIDTH        = 48,
    parameter int unsigned HEIGHT       = 64,
    parameter logic [11:0] COLOR        = 12'hf_0_f,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    vga_if.in           vga_in,
    vga_if.out          vga_out
);

    logic [11:0] x_lat;
    logic [11:0] y_lat;
    logic        vblnk_q;
    logic        frame_start;
    logic        visible;

    assign frame_start = !vblnk_q && vga_in.vblnk;

    // Position is captured once per frame on the vblank rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_lat   <= '0;
            y_lat   <= '0;
            vblnk_q <= 1'b0;
        end else begin
            vblnk_q <= vga_in.vblnk;
            if (frame_start) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

`ifdef DRAW_RECT_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_FRAMES + 1);

    logic [CNT_W-1:0] blink_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    assign visible = 1'b1;
`endif

    // 13-bit compare so x_lat+WIDTH never wraps back onto the left edge.
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic [12:0] x_beg;
    logic [12:0] y_beg;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        in_rect;

    always_comb begin
        h_ext   = {2'b00, vga_in.hcount};
        v_ext   = {2'b00, vga_in.vcount};
        x_beg   = {1'b0, x_lat};
        y_beg   = {1'b0, y_lat};
        x_end   = x_beg + 13'(WIDTH);
        y_end   = y_beg + 13'(HEIGHT);
        in_rect = (h_ext >= x_beg) && (h_ext < x_end) &&
                  (v_ext >= y_beg) && (v_ext < y_end);
    end

    logic [10:0] vcount_d1;
    logic [10:0] hcount_d1;
    logic        vsync_d1;
    logic        vblnk_d1;
    logic        hsync_d1;
    logic        hblnk_d1;
    logic [11:0] rgb_d1;
    logic        in_rect_d1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcount_d1  <= '0;
            hcount_d1  <= '0;
            vsync_d1   <= 1'b0;
            vblnk_d1   <= 1'b0;
            hsync_d1   <= 1'b0;
            hblnk_d1   <= 1'b0;
            rgb_d1     <= '0;
            in_rect_d1 <= 1'b0;
        end else begin
            vcount_d1  <= vga_in.vcount;
            hcount_d1  <= vga_in.hcount;
            vsync_d1   <= vga_in.vsync;
            vblnk_d1   <= vga_in.vblnk;
            hsync_d1   <= vga_in.hsync;
            hblnk_d1   <= vga_in.hblnk;
            rgb_d1     <= vga_in.rgb;
            in_rect_d1 <= in_rect;
        end
    end

    logic [10:0] vcount_d2;
    logic [10:0] hcount_d2;
    logic        vsync_d2;
    logic        vblnk_d2;
    logic        hsync_d2;
    logic        hblnk_d2;
    logic [11:0] rgb_d2;
    logic        paint;

    assign paint = in_rect_d1 && !hblnk_d1 && !vblnk_d1 && visible;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcount_d2 <= '0;
            hcount_d2 <= '0;
            vsync_d2  <= 1'b0;
            vblnk_d2  <= 1'b0;
            hsync_d2  <= 1'b0;
            hblnk_d2  <= 1'b0;
            rgb_d2    <= '0;
        end else begin
            vcount_d2 <= vcount_d1;
            hcount_d2 <= hcount_d1;
            vsync_d2  <= vsync_d1;
            vblnk_d2  <= vblnk_d1;
            hsync_d2  <= hsync_d1;
            hblnk_d2  <= hblnk_d1;
            rgb_d2    <= paint ? COLOR : rgb_d1;
        end
    end

    assign vga_out.vcount = vcount_d2;
    assign vga_out.hcount = hcount_d2;
    assign vga_out.vsync  = vsync_d2;
    assign vga_out.vblnk  = vblnk_d2;
    assign vga_out.hsync  = hsync_d2;
    assign vga_out.hblnk  = hblnk_d2;
    assign vga_out.rgb    = rgb_d2;

endmodule
